tpc_wr_arbiter: RTL and testbench
=================================

# tpc_wr_arbiter

Four-input write-request arbiter between the to-PC FIFO channels and the PCIe TX engine. It collects burst write requests (address + 64-bit data beats, terminated by `last`) from up to four TPC FIFO channels. It grants one channel at a time in round-robin order and forwards that channel's entire burst to a single registered output stream. The output stream feeds `pcie_tx` write-request inputs.

## Interface
Parameters:
- `NCH`, 4: number of input channels; fixed at 4 in this revision.

Ports:
- `clock`  in  1  system PCIe user clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wri_valid`  in  4  per-channel beat valid.
- `wri_ready`  out  4  per-channel beat accept; at most one bit set.
- `wri_last`  in  4  per-channel last beat of burst.
- `wri_addr_0..3`  in  64 each  per-channel beat address.
- `wri_data_0..3`  in  64 each  per-channel beat data.
- `wro_valid`  out  1  output beat valid.
- `wro_ready`  in  1  TX accepts output beat.
- `wro_addr`  out  64  output beat address.
- `wro_data`  out  64  output beat data.
- `wro_last`  out  1  output last beat.
- `grant`  out  2  index of the channel currently owning the output.
- `busy`  out  1  high while in BURST state.

## Operation
- **State machine: IDLE, BURST.**
- **IDLE**
  - Search for the first channel with `wri_valid` set, starting at `rr_ptr` and wrapping modulo 4.
  - If one is found, register `grant` to that channel and go to BURST next cycle.
  - No beat is accepted in IDLE.
- **BURST**
  - `wri_ready[grant] = ~wro_valid | wro_ready`; all other `wri_ready` bits are 0.
  - A beat is accepted when `wri_valid[grant] & wri_ready[grant]`.
  - Accepted addr, data and last are loaded into the output register, and `wro_valid` is set.
  - If `wro_ready` is high and no beat is loaded, `wro_valid` clears.
  - When the accepted beat has `last`=1:
    - go to IDLE;
    - set `rr_ptr <= grant + 1` (2-bit wrap, 3 -> 0).
  - A bubble on the granted channel (`wri_valid`=0) leaves the state in BURST. Other channels are never granted mid-burst.
- **Output register:** a single stage. It is overwritten only when empty or emptying in the same cycle. No beat is dropped or duplicated.
- **Single-beat bursts:** legal. `last` on the first beat returns the state machine to IDLE.
- **Ordering:** beats within a burst leave in arrival order. Address is passed per beat, unmodified.
- **Reset (`reset_n` low, at any time, including mid-burst):**
  - state = IDLE, `rr_ptr` = 0, `grant` = 0;
  - `wro_valid` = 0, `wro_last` = 0, `wro_addr` = 0, `wro_data` = 0;
  - `wri_ready` = 0, `busy` = 0.
  - The partial burst is discarded; upstream is reset by the same reset.

## Timing
- **Arbitration latency:** 1 cycle. The request is seen in IDLE at cycle N; state is BURST with `wri_ready` high at N+1.
- **Data latency:** 1 cycle. A beat accepted at edge N is presented on `wro_*` after edge N.
- **Throughput:** one beat per cycle while `wro_ready`=1 and the granted channel is valid.
- **Inter-burst gap:** exactly one IDLE cycle with no input accept. Output may still drain during that cycle.
- **Combinational paths:** `wri_ready` depends on `wro_ready` (combinational, AXI-stream style). All other outputs are registered.
- **Stable output:** `wro_*` is held stable while `wro_valid & ~wro_ready`.

## Test plan
- **Reset values:** assert `reset_n`=0 for 3 cycles, then release -> all outputs 0 and `busy`=0; after one further idle cycle with no valid inputs, still all 0.
- **Single channel, 4-beat burst:** ch2, addr 0x1000..0x1018, data 1..4, `last` on beat 4, `wro_ready`=1 -> `grant`=2; four consecutive `wro_valid` beats with matching addr/data; `wro_last` only on the 4th; returns to IDLE; `rr_ptr`=3.
- **Round-robin fairness:** all four channels continuously valid with 2-beat bursts -> grant order 0,1,2,3,0; one-cycle gap between bursts; no interleaving of channels.
- **Backpressure:** ch0 8-beat burst with `wro_ready` toggled 1,0,0,1,… -> output held stable while stalled; all 8 beats delivered in order; `wri_ready[0]` low only when the register is full and stalled.
- **Single-beat bursts back-to-back:** ch1 and ch3, each with `last` on every beat -> alternating grants 1,3,1,3; each beat delivered with `wro_last`=1.
- **Reset mid-burst:** after 3 of 6 beats of a ch1 burst, pulse `reset_n` low for 1 cycle -> `wro_valid` drops immediately (async); state IDLE, `rr_ptr`=0; a new ch1 request afterward is granted normally.

Source files
------------

// File: rtl/tpc_wr_arbiter.sv
// rtl/tpc_wr_arbiter.sv - four-channel round-robin burst write arbiter feeding pcie_tx
module tpc_wr_arbiter #(
   parameter int NCH = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [NCH-1:0]  wri_valid,
   output logic [NCH-1:0]  wri_ready,
   input  logic [NCH-1:0]  wri_last,
   input  logic [63:0]     wri_addr_0,
   input  logic [63:0]     wri_addr_1,
   input  logic [63:0]     wri_addr_2,
   input  logic [63:0]     wri_addr_3,
   input  logic [63:0]     wri_data_0,
   input  logic [63:0]     wri_data_1,
   input  logic [63:0]     wri_data_2,
   input  logic [63:0]     wri_data_3,
   output logic            wro_valid,
   input  logic            wro_ready,
   output logic [63:0]     wro_addr,
   output logic [63:0]     wro_data,
   output logic            wro_last,
   output logic [1:0]      grant,
   output logic            busy
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_d;
   logic [1:0]  rr_q, rr_d;
   logic [1:0]  idx;
   logic        found;
   logic        take;
   logic [63:0] sel_addr, sel_data;
   logic        sel_last;

   assign busy = (state_q == BURST);

   // Route the granted channel's beat fields toward the output register.
   always_comb begin
      sel_addr = wri_addr_0;
      sel_data = wri_data_0;
      case (grant)
         2'd1: begin sel_addr = wri_addr_1; sel_data = wri_data_1; end
         2'd2: begin sel_addr = wri_addr_2; sel_data = wri_data_2; end
         2'd3: begin sel_addr = wri_addr_3; sel_data = wri_data_3; end
         default: begin sel_addr = wri_addr_0; sel_data = wri_data_0; end
      endcase
      sel_last = wri_last[grant];
   end

   // Arbitration in IDLE, beat acceptance and burst termination in BURST.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant;
      rr_d      = rr_q;
      wri_ready = '0;
      take      = 1'b0;
      found     = 1'b0;
      idx       = rr_q;
      case (state_q)
         IDLE: begin
            for (int i = 0; i < 4; i++) begin
               idx = rr_q + 2'(i);
               if (!found && wri_valid[idx]) begin
                  found   = 1'b1;
                  grant_d = idx;
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            wri_ready[grant] = ~wro_valid | wro_ready;
            take = wri_valid[grant] & wri_ready[grant];
            if (take && sel_last) begin
               state_d = IDLE;
               rr_d    = grant + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant   <= 2'd0;
         rr_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
         rr_q    <= rr_d;
      end
   end

   // Single-stage output register: load on accept, otherwise drain when the sink takes it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wro_valid <= 1'b0;
         wro_addr  <= 64'd0;
         wro_data  <= 64'd0;
         wro_last  <= 1'b0;
      end else if (take) begin
         wro_valid <= 1'b1;
         wro_addr  <= sel_addr;
         wro_data  <= sel_data;
         wro_last  <= sel_last;
      end else if (wro_ready) begin
         wro_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tpc_wr_arbiter.sv
// tb/tb_tpc_wr_arbiter.sv - randomized self-checking bench for tpc_wr_arbiter
module tb_tpc_wr_arbiter;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  wri_valid = '0;
   logic [3:0]  wri_ready;
   logic [3:0]  wri_last = '0;
   logic [63:0] a_drv [4];
   logic [63:0] d_drv [4];
   logic        wro_valid;
   logic        wro_ready = 1'b0;
   logic [63:0] wro_addr, wro_data;
   logic        wro_last;
   logic [1:0]  grant;
   logic        busy;

   int total = 0;
   int bad = 0;

   beat_t       src [4][$];
   beat_t       expq[$];
   logic [3:0]  vld = '0;
   bit          m_busy = 1'b0;
   int          m_grant = 0;
   int          m_rr = 0;
   bit          stall_prev = 1'b0;
   logic [63:0] h_addr, h_data;
   logic        h_last;
   logic [63:0] next_addr = 64'h1_0000;
   int          in_acc = 0;

   tpc_wr_arbiter #(.NCH(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .wri_valid(wri_valid), .wri_ready(wri_ready), .wri_last(wri_last),
      .wri_addr_0(a_drv[0]), .wri_addr_1(a_drv[1]), .wri_addr_2(a_drv[2]), .wri_addr_3(a_drv[3]),
      .wri_data_0(d_drv[0]), .wri_data_1(d_drv[1]), .wri_data_2(d_drv[2]), .wri_data_3(d_drv[3]),
      .wro_valid(wro_valid), .wro_ready(wro_ready), .wro_addr(wro_addr), .wro_data(wro_data),
      .wro_last(wro_last), .grant(grant), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_burst(input int c, input int len, input logic [63:0] base, input bit seq_data);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.addr = base + 64'(8 * k);
         b.data = seq_data ? 64'(k + 1) : {$urandom, $urandom};
         b.last = (k == len - 1);
         src[c].push_back(b);
      end
   endtask

   task automatic push_rand(input int c, input int len);
      push_burst(c, len, next_addr, 1'b0);
      next_addr = next_addr + 64'h100;
   endtask

   task automatic drive(input int bubble_pct, input int rdy_pct);
      for (int c = 0; c < 4; c++) begin
         if (!vld[c] && src[c].size() > 0 && int'($urandom_range(99)) >= bubble_pct)
            vld[c] = 1'b1;
         if (src[c].size() > 0) begin
            a_drv[c]    = src[c][0].addr;
            d_drv[c]    = src[c][0].data;
            wri_last[c] = src[c][0].last;
         end else begin
            a_drv[c]    = 64'd0;
            d_drv[c]    = 64'd0;
            wri_last[c] = 1'b0;
         end
      end
      wri_valid = vld;
      wro_ready = (int'($urandom_range(99)) < rdy_pct);
   endtask

   // One clock: drive at the falling edge, check just after, then advance the model for the rising edge.
   task automatic step(input int bubble_pct, input int rdy_pct);
      logic [3:0] hs;
      bit         ohs;
      bit         found;
      beat_t      ob;
      @(negedge clock);
      drive(bubble_pct, rdy_pct);
      #1;
      chk("busy", busy, m_busy);
      chk("ready_onehot", $onehot0(wri_ready), 1);
      if (m_busy) begin
         chk("grant", grant, m_grant);
         chk("ready_granted", wri_ready, (~wro_valid | wro_ready) ? (64'd1 << m_grant) : 64'd0);
      end else begin
         chk("ready_idle", wri_ready, 0);
      end
      if (stall_prev) begin
         chk("hold_valid", wro_valid, 1);
         chk("hold_addr", wro_addr, h_addr);
         chk("hold_data", wro_data, h_data);
         chk("hold_last", wro_last, h_last);
      end
      hs  = wri_valid & wri_ready;
      ohs = wro_valid & wro_ready;
      if (ohs) begin
         if (expq.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            ob = expq.pop_front();
            chk("out_addr", wro_addr, ob.addr);
            chk("out_data", wro_data, ob.data);
            chk("out_last", wro_last, ob.last);
         end
      end
      stall_prev = wro_valid & ~wro_ready;
      h_addr = wro_addr;
      h_data = wro_data;
      h_last = wro_last;
      if (!m_busy) begin
         chk("idle_accept", hs, 0);
         found = 1'b0;
         for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_rr + i) % 4;
            if (!found && vld[c]) begin
               found   = 1'b1;
               m_busy  = 1'b1;
               m_grant = c;
               for (int k = 0; k < src[c].size(); k++) begin
                  expq.push_back(src[c][k]);
                  if (src[c][k].last) break;
               end
            end
         end
      end else begin
         chk("foreign_accept", hs & ~(4'b1 << m_grant), 0);
         if (hs[m_grant]) begin
            in_acc++;
            ob = src[m_grant].pop_front();
            vld[m_grant] = 1'b0;
            if (ob.last) begin
               m_busy = 1'b0;
               m_rr   = (m_grant + 1) % 4;
            end
         end
      end
   endtask

   function automatic bit all_done();
      return !m_busy && expq.size() == 0 && src[0].size() == 0 && src[1].size() == 0
             && src[2].size() == 0 && src[3].size() == 0;
   endfunction

   task automatic run(input int bubble_pct, input int rdy_pct, input int limit);
      int n;
      n = 0;
      while (!all_done() && n < limit) begin
         step(bubble_pct, rdy_pct);
         n++;
      end
      step(bubble_pct, 100);
      chk("drain_timeout", all_done(), 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_wro_valid"}, wro_valid, 0);
      chk({tag, "_wro_last"}, wro_last, 0);
      chk({tag, "_wro_addr"}, wro_addr, 0);
      chk({tag, "_wro_data"}, wro_data, 0);
      chk({tag, "_wri_ready"}, wri_ready, 0);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      for (int c = 0; c < 4; c++) begin
         a_drv[c] = 64'd0;
         d_drv[c] = 64'd0;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_zero("reset");
      step(0, 100);
      #1;
      check_zero("idle");

      push_burst(2, 4, 64'h1000, 1'b1);
      run(0, 100, 50);

      push_burst(0, 1, 64'h2000, 1'b1);
      push_burst(3, 1, 64'h3000, 1'b1);
      run(0, 100, 50);

      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) push_rand(c, 2);
      push_rand(0, 2);
      run(0, 100, 100);

      push_rand(0, 8);
      run(0, 50, 200);

      for (int r = 0; r < 4; r++) begin
         push_rand(1, 1);
         push_rand(3, 1);
      end
      run(0, 100, 100);

      for (int r = 0; r < 40; r++) push_rand(int'($urandom_range(3)), int'($urandom_range(1, 6)));
      run(30, 60, 3000);

      push_rand(1, 6);
      push_rand(2, 3);
      in_acc = 0;
      for (int n = 0; n < 50 && in_acc < 3; n++) step(0, 100);
      chk("mid_reset_reached", in_acc, 3);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_zero("mid_reset");
      for (int c = 0; c < 4; c++) src[c].delete();
      expq.delete();
      vld        = '0;
      wri_valid  = '0;
      m_busy     = 1'b0;
      m_rr       = 0;
      stall_prev = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      push_rand(1, 3);
      push_rand(0, 2);
      run(0, 80, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
